rs232_rx: RTL
=============

RS232_RX -- requirements
Module: rs232_rx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: rx_data  input  1  asynchronous serial line; idles high.
REQ-005 SHALL have port: data  output  8  last correctly framed received byte.
REQ-006 SHALL have port: valid  output  1  one-cycle pulse when data is updated.
REQ-007 SHALL have port: frame_err  output  1  one-cycle pulse on a bad stop bit.

Function
REQ-008 SHALL accept frames of 1 start bit (0), 8 data bits sent LSB first, and 1 stop bit (1); no parity.
REQ-009 SHALL pass rx_data through a 2-flop synchronizer; rx_s (the second flop) is the only value the FSM samples.
REQ-010 SHALL implement states IDLE, START, DATA, STOP and BREAK.
REQ-011 SHALL define H = CLKS_PER_BIT/2 (integer division) and N = CLKS_PER_BIT; the cycle counter cnt SHALL be ceil(log2(N)) bits wide.
REQ-012 IDLE: hold cnt=0; on rx_s==0 go to START with cnt=0.
REQ-013 START: increment cnt each cycle; at cnt==H-1, if rx_s==0 go to DATA with cnt=0 and bit_idx=0, otherwise treat as a glitch and return to IDLE with no output pulse.
REQ-014 DATA: increment cnt each cycle; at cnt==N-1 shift rx_s into bit position bit_idx and clear cnt; after bit_idx==7 go to STOP, otherwise increment bit_idx.
REQ-015 STOP: at cnt==N-1, if rx_s==1 load data from the shift register, pulse valid for exactly 1 cycle and go to IDLE.
REQ-016 STOP: at cnt==N-1, if rx_s==0 pulse frame_err for 1 cycle, leave data and valid unchanged and go to BREAK.
REQ-017 BREAK: remain until rx_s==1, then go to IDLE; a held-low line SHALL NOT be decoded as new start bits.
REQ-018 Latency: if edge k is the first clk edge to sample rx_data low, valid SHALL be high in the cycle following edge k+2+H+9N (k+154 when N=16).
REQ-019 valid and frame_err SHALL never be high in the same cycle and SHALL each be high for at most 1 cycle per frame.
REQ-020 data SHALL change only in the cycle that valid pulses.
REQ-021 A start bit arriving in the cycle IDLE is re-entered after a good stop bit SHALL be accepted, so back-to-back frames with a 1-bit stop lose no data.
REQ-022 rx_data activity during START, DATA or STOP SHALL affect only the sampled bit; no early resynchronization is performed.

Reset
REQ-023 rst==1 at a clk edge SHALL force state=IDLE, cnt=0, bit_idx=0, shift register=0, data=8'h00, valid=0, frame_err=0 and both synchronizer flops=1.
REQ-024 rst SHALL take priority over all other activity, including mid-frame; the partially received frame SHALL be discarded with no valid or frame_err pulse.
REQ-025 After rst is released, a frame SHALL be accepted only once a fresh high-to-low edge reaches rx_s.

Verification
REQ-026 N=16: send 0xA5 with a correct stop bit -> data=8'hA5, valid high for exactly 1 cycle at k+154, frame_err stays 0.
REQ-027 Drive rx_data low for 3 cycles, then high -> FSM returns to IDLE, no valid or frame_err pulse, data unchanged.
REQ-028 Send 0x3C with stop bit 0, then hold the line low for 40 bit times, then high, then send 0x81 -> one frame_err pulse, data stays at its prior value, then data=8'h81 with one valid pulse.
REQ-029 Send 0x00 and 0xFF back-to-back with exactly N-cycle stop bits -> two valid pulses exactly 10N cycles apart, with data 8'h00 then 8'hFF.
REQ-030 Assert rst for 1 cycle during data bit 4 of a frame -> all outputs take their reset values, no pulse for the aborted frame, and the next full frame decodes correctly.
REQ-031 Repeat the REQ-026 scenario with N=4 and N=17 -> correct byte, and latency matches REQ-018 with H=2 and H=8 respectively.

Source files
------------

// File: rtl/rs232_rx.sv
// rs232_rx: 8N1 serial receiver with a 2-flop input synchronizer.
// Samples mid-bit from a half-bit start check and reports bad stop bits.
module rs232_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_data,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int N  = CLKS_PER_BIT;
    localparam int H  = N / 2;
    localparam int CW = $clog2(N);

    localparam logic [CW-1:0] C_HALF = CW'(H - 1);
    localparam logic [CW-1:0] C_FULL = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_sync1;
    logic            r_sync2;
    logic            w_rx_s;

    assign w_rx_s = r_sync2;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_data;
            r_sync2 <= r_sync1;
        end
    end

    // Frame FSM: start check at half bit, then sample each bit centre.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_s) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == C_HALF) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        if (w_rx_s) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == C_FULL) begin
                        r_cnt <= '0;
                        r_shift[r_bit_idx] <= w_rx_s;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == C_FULL) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            data    <= r_shift;
                            valid   <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    r_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
